time_set_controller: RTL and testbench

- Sequences the set-up of an HH:MM:SS time value from the single-cycle increment pulses produced by the team's pushbutton auto-repeat FSM instances (mode, next-field, increment, decrement).
- Runs the time from a 1 Hz tick in RUN mode.
- In EDIT mode it pauses the time, owns one selected field, and applies button pulses to that field with wrap-around.
- Drives a blink enable for the display driver so the selected field flashes.

---
 rtl/time_set_controller.sv | 262 ++++++++++++++++++++++++++
 tb/tb_time_set_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
//
// Keeps an HH:MM:SS time value. Two modes:
//   RUN  - the time advances on each tick_1hz pulse. On the 23:59:59 to
//          00:00:00 wrap, rollover_pulse is high for one cycle.
//   EDIT - the time is frozen. One field (hours, minutes or seconds) is
//          selected. inc/dec pulses change that field with wrap-around and
//          never carry into another field. blink_on flashes the selected
//          field on the display.
//
// The button inputs are single-cycle pulses from the pushbutton
// auto-repeat FSMs.
//
// Parameters:
//   BLINK_HALF     clock cycles per blink half-period in EDIT (>= 2)
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            synchronous reset, active-high
//   tick_1hz       one-cycle pulse, once per second
//   mode_pulse     toggles RUN / EDIT
//   next_pulse     advances the selected field (H -> M -> S -> H)
//   inc_pulse      +1 on the selected field
//   dec_pulse      -1 on the selected field
//   hours          0..23, registered
//   minutes        0..59, registered
//   seconds        0..59, registered
//   edit_active    high in any EDIT state
//   field_sel      one-hot selected field: [2]=H [1]=M [0]=S, 000 in RUN
//   blink_on       display enable for the selected field
//   rollover_pulse one-cycle pulse on the midnight wrap in RUN
// ---------------------------------------------------------------------------
module time_set_controller #(
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_pulse,
    input  logic       next_pulse,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       edit_active,
    output logic [2:0] field_sel,
    output logic       blink_on,
    output logic       rollover_pulse
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT_H = 2'd1,
        ST_EDIT_M = 2'd2,
        ST_EDIT_S = 2'd3
    } state_e;

    localparam int unsigned          CNT_W    = $clog2(BLINK_HALF);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BLINK_HALF - 1);

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MS_MAX   = 6'd59;

    // -----------------------------------------------------------------------
    // Wrap helpers. All field arithmetic uses an explicit compare against the
    // field maximum. Hours go through these helpers zero-extended to 6 bits.
    // -----------------------------------------------------------------------
    function automatic logic [5:0] wrap_inc(input logic [5:0] val,
                                            input logic [5:0] max);
        return (val == max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] val,
                                            input logic [5:0] max);
        return (val == 6'd0) ? max : val - 6'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Registers and next-state signals
    // -----------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [4:0]       hours_q,    hours_d;
    logic [5:0]       minutes_q,  minutes_d;
    logic [5:0]       seconds_q,  seconds_d;
    logic             rollover_q, rollover_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q,    blink_d;

    // Decoded control
    logic run_tick;      // tick that actually advances the time
    logic field_cmd_ok;  // EDIT, with no higher-priority pulse in this cycle
    logic inc_acc;       // accepted increment
    logic dec_acc;       // accepted decrement
    logic state_change;

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // mode_pulse has priority over next_pulse. next_pulse is ignored in RUN.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first. A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (mode_pulse) state_d = ST_EDIT_H;
            end
            ST_EDIT_H: begin
                if (mode_pulse)      state_d = ST_RUN;
                else if (next_pulse) state_d = ST_EDIT_M;
            end
            ST_EDIT_M: begin
                if (mode_pulse)      state_d = ST_RUN;
                else if (next_pulse) state_d = ST_EDIT_S;
            end
            ST_EDIT_S: begin
                if (mode_pulse)      state_d = ST_RUN;
                else if (next_pulse) state_d = ST_EDIT_H;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: Moore outputs decoded from the state register
    // -----------------------------------------------------------------------
    always_comb begin
        edit_active = (state_q != ST_RUN);
        field_sel   = 3'b000;
        unique case (state_q)
            ST_EDIT_H: field_sel = 3'b100;
            ST_EDIT_M: field_sel = 3'b010;
            ST_EDIT_S: field_sel = 3'b001;
            default:   field_sel = 3'b000;
        endcase
    end

    // -----------------------------------------------------------------------
    // Input qualification. In EDIT only one action happens per cycle:
    // mode > next > inc/dec. An inc and a dec in the same cycle cancel.
    // A pulse that loses is dropped, not queued.
    // -----------------------------------------------------------------------
    always_comb begin
        run_tick     = (state_q == ST_RUN) && tick_1hz;
        field_cmd_ok = (state_q != ST_RUN) && !mode_pulse && !next_pulse;
        inc_acc      = field_cmd_ok && inc_pulse && !dec_pulse;
        dec_acc      = field_cmd_ok && dec_pulse && !inc_pulse;
        state_change = (state_d != state_q);
    end

    // -----------------------------------------------------------------------
    // Time datapath: RUN counting and EDIT field arithmetic
    // -----------------------------------------------------------------------
    always_comb begin
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        rollover_d = 1'b0;

        if (run_tick) begin
            // A tick that arrives with mode_pulse is still applied, because
            // the state register is still RUN on this edge.
            rollover_d = ({1'b0, hours_q} == HOUR_MAX) &&
                         (minutes_q == MS_MAX) && (seconds_q == MS_MAX);
            seconds_d  = wrap_inc(seconds_q, MS_MAX);
            if (seconds_q == MS_MAX) begin
                minutes_d = wrap_inc(minutes_q, MS_MAX);
                if (minutes_q == MS_MAX) begin
                    hours_d = 5'(wrap_inc({1'b0, hours_q}, HOUR_MAX));
                end
            end
        end else if (inc_acc || dec_acc) begin
            unique case (state_q)
                ST_EDIT_H: begin
                    hours_d = inc_acc ? 5'(wrap_inc({1'b0, hours_q}, HOUR_MAX))
                                      : 5'(wrap_dec({1'b0, hours_q}, HOUR_MAX));
                end
                ST_EDIT_M: begin
                    minutes_d = inc_acc ? wrap_inc(minutes_q, MS_MAX)
                                        : wrap_dec(minutes_q, MS_MAX);
                end
                ST_EDIT_S: begin
                    seconds_d = inc_acc ? wrap_inc(seconds_q, MS_MAX)
                                        : wrap_dec(seconds_q, MS_MAX);
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Blink generator. A state change or an accepted inc/dec restarts the
    // period with the field lit, so the new value shows at once. In RUN the
    // counter is held at 0 and the display stays on.
    // -----------------------------------------------------------------------
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        if (state_change || inc_acc || dec_acc) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (state_q == ST_RUN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            rollover_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            rollover_q  <= rollover_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign hours          = hours_q;
    assign minutes        = minutes_q;
    assign seconds        = seconds_q;
    assign blink_on       = blink_q;
    assign rollover_pulse = rollover_q;

endmodule

// File: tb/tb_time_set_controller.sv
// ---------------------------------------------------------------------------
// tb_time_set_controller
//
// Table-driven bench with a scoreboard. Each record holds one cycle of
// input pulses and the outputs required after that edge. The record is
// pushed to a queue as its stimulus is driven. It is popped and compared
// 1 ns after the rising edge. A few hand-written sequences cover the
// longer corner cases. BLINK_HALF is 4 so blink periods stay short.
// ---------------------------------------------------------------------------
module tb_time_set_controller;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       mode;
        logic       next;
        logic       inc;
        logic       dec;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       edit;
        logic [2:0] fsel;
        logic       blink;
        logic       roll;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       mode_pulse;
    logic       next_pulse;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       edit_active;
    logic [2:0] field_sel;
    logic       blink_on;
    logic       rollover_pulse;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];
    vec_t vecs[$];

    time_set_controller #(.BLINK_HALF(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1hz      (tick_1hz),
        .mode_pulse    (mode_pulse),
        .next_pulse    (next_pulse),
        .inc_pulse     (inc_pulse),
        .dec_pulse     (dec_pulse),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .edit_active   (edit_active),
        .field_sel     (field_sel),
        .blink_on      (blink_on),
        .rollover_pulse(rollover_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Input bit order: {rst, tick, mode, next, inc, dec}
    function automatic vec_t v(input logic [5:0] in_bits, input int h,
                               input int m, input int s, input logic e,
                               input logic [2:0] f, input logic b,
                               input logic r);
        vec_t t;
        t.rst   = in_bits[5];
        t.tick  = in_bits[4];
        t.mode  = in_bits[3];
        t.next  = in_bits[2];
        t.inc   = in_bits[1];
        t.dec   = in_bits[0];
        t.h     = 5'(h);
        t.m     = 6'(m);
        t.s     = 6'(s);
        t.edit  = e;
        t.fsel  = f;
        t.blink = b;
        t.roll  = r;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare(input string tag);
        vec_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".hours"},    8'(hours),          8'(e.h));
            check({tag, ".minutes"},  8'(minutes),        8'(e.m));
            check({tag, ".seconds"},  8'(seconds),        8'(e.s));
            check({tag, ".edit"},     8'(edit_active),    8'(e.edit));
            check({tag, ".fsel"},     8'(field_sel),      8'(e.fsel));
            check({tag, ".blink"},    8'(blink_on),       8'(e.blink));
            check({tag, ".rollover"}, 8'(rollover_pulse), 8'(e.roll));
        end
    endtask

    task automatic step(input vec_t t, input string tag);
        @(negedge clk);
        rst        = t.rst;
        tick_1hz   = t.tick;
        mode_pulse = t.mode;
        next_pulse = t.next;
        inc_pulse  = t.inc;
        dec_pulse  = t.dec;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        rst        = 1'b1;
        tick_1hz   = 1'b0;
        mode_pulse = 1'b0;
        next_pulse = 1'b0;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;

        //                in        h   m   s  e  fsel   b  r
        vecs.push_back(v(6'b100000,  0,  0,  0, 0, 3'b000, 1, 0)); //  0 reset
        vecs.push_back(v(6'b010000,  0,  0,  1, 0, 3'b000, 1, 0)); //  1 tick
        vecs.push_back(v(6'b010000,  0,  0,  2, 0, 3'b000, 1, 0)); //  2 tick
        vecs.push_back(v(6'b010000,  0,  0,  3, 0, 3'b000, 1, 0)); //  3 tick
        vecs.push_back(v(6'b000000,  0,  0,  3, 0, 3'b000, 1, 0)); //  4 idle
        vecs.push_back(v(6'b001000,  0,  0,  3, 1, 3'b100, 1, 0)); //  5 mode -> EDIT_H
        vecs.push_back(v(6'b000001, 23,  0,  3, 1, 3'b100, 1, 0)); //  6 dec at 0 -> 23
        vecs.push_back(v(6'b000100, 23,  0,  3, 1, 3'b010, 1, 0)); //  7 next -> EDIT_M
        vecs.push_back(v(6'b000001, 23, 59,  3, 1, 3'b010, 1, 0)); //  8 dec at 0 -> 59
        vecs.push_back(v(6'b000100, 23, 59,  3, 1, 3'b001, 1, 0)); //  9 next -> EDIT_S
        vecs.push_back(v(6'b000001, 23, 59,  2, 1, 3'b001, 1, 0)); // 10
        vecs.push_back(v(6'b000001, 23, 59,  1, 1, 3'b001, 1, 0)); // 11
        vecs.push_back(v(6'b000001, 23, 59,  0, 1, 3'b001, 1, 0)); // 12
        vecs.push_back(v(6'b000001, 23, 59, 59, 1, 3'b001, 1, 0)); // 13 0 - 1 -> 59
        vecs.push_back(v(6'b000010, 23, 59,  0, 1, 3'b001, 1, 0)); // 14 59 + 1 -> 0, no carry
        vecs.push_back(v(6'b000001, 23, 59, 59, 1, 3'b001, 1, 0)); // 15
        vecs.push_back(v(6'b000001, 23, 59, 58, 1, 3'b001, 1, 0)); // 16 preload 23:59:58
        vecs.push_back(v(6'b010000, 23, 59, 58, 1, 3'b001, 1, 0)); // 17 tick ignored in EDIT
        vecs.push_back(v(6'b001000, 23, 59, 58, 0, 3'b000, 1, 0)); // 18 mode -> RUN
        vecs.push_back(v(6'b010000, 23, 59, 59, 0, 3'b000, 1, 0)); // 19 no rollover yet
        vecs.push_back(v(6'b010000,  0,  0,  0, 0, 3'b000, 1, 1)); // 20 rollover
        vecs.push_back(v(6'b000000,  0,  0,  0, 0, 3'b000, 1, 0)); // 21 pulse ends
        vecs.push_back(v(6'b001000,  0,  0,  0, 1, 3'b100, 1, 0)); // 22 EDIT_H
        vecs.push_back(v(6'b000100,  0,  0,  0, 1, 3'b010, 1, 0)); // 23 EDIT_M
        vecs.push_back(v(6'b000011,  0,  0,  0, 1, 3'b010, 1, 0)); // 24 inc+dec dropped
        vecs.push_back(v(6'b000110,  0,  0,  0, 1, 3'b001, 1, 0)); // 25 next+inc: next wins
        vecs.push_back(v(6'b000100,  0,  0,  0, 1, 3'b100, 1, 0)); // 26 EDIT_S -> EDIT_H
        vecs.push_back(v(6'b000100,  0,  0,  0, 1, 3'b010, 1, 0)); // 27 EDIT_M
        vecs.push_back(v(6'b001010,  0,  0,  0, 0, 3'b000, 1, 0)); // 28 mode+inc: mode wins
        vecs.push_back(v(6'b011000,  0,  0,  1, 1, 3'b100, 1, 0)); // 29 tick+mode in RUN
        vecs.push_back(v(6'b000000,  0,  0,  1, 1, 3'b100, 1, 0)); // 30 cnt 1
        vecs.push_back(v(6'b000000,  0,  0,  1, 1, 3'b100, 1, 0)); // 31 cnt 2
        vecs.push_back(v(6'b000000,  0,  0,  1, 1, 3'b100, 1, 0)); // 32 cnt 3
        vecs.push_back(v(6'b000000,  0,  0,  1, 1, 3'b100, 0, 0)); // 33 toggle off
        vecs.push_back(v(6'b000000,  0,  0,  1, 1, 3'b100, 0, 0)); // 34 cnt 1
        vecs.push_back(v(6'b000010,  1,  0,  1, 1, 3'b100, 1, 0)); // 35 inc forces blink on
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 1, 0)); // 36 cnt 1
        vecs.push_back(v(6'b010000,  1,  0,  1, 1, 3'b100, 1, 0)); // 37 tick frozen, cnt 2
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 1, 0)); // 38 cnt 3
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 0, 0)); // 39 toggle off
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 0, 0)); // 40
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 0, 0)); // 41
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 0, 0)); // 42
        vecs.push_back(v(6'b000000,  1,  0,  1, 1, 3'b100, 1, 0)); // 43 toggle on
        vecs.push_back(v(6'b001000,  1,  0,  1, 0, 3'b000, 1, 0)); // 44 back to RUN
        vecs.push_back(v(6'b000111,  1,  0,  1, 0, 3'b000, 1, 0)); // 45 next/inc/dec ignored
        vecs.push_back(v(6'b010000,  1,  0,  2, 0, 3'b000, 1, 0)); // 46 counting resumes

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Build 12:34:56 through EDIT, let blink go dark, then reset mid-edit.
        step(v(6'b100000, 0, 0, 0, 0, 3'b000, 1, 0), "seq_rst");
        step(v(6'b001000, 0, 0, 0, 1, 3'b100, 1, 0), "seq_enter");
        for (int k = 1; k <= 12; k++)
            step(v(6'b000010, k, 0, 0, 1, 3'b100, 1, 0), $sformatf("seq_h%0d", k));
        step(v(6'b000100, 12, 0, 0, 1, 3'b010, 1, 0), "seq_to_m");
        for (int k = 1; k <= 34; k++)
            step(v(6'b000010, 12, k, 0, 1, 3'b010, 1, 0), $sformatf("seq_m%0d", k));
        step(v(6'b000100, 12, 34, 0, 1, 3'b001, 1, 0), "seq_to_s");
        for (int k = 1; k <= 56; k++)
            step(v(6'b000010, 12, 34, k, 1, 3'b001, 1, 0), $sformatf("seq_s%0d", k));
        for (int k = 1; k <= 4; k++)
            step(v(6'b000000, 12, 34, 56, 1, 3'b001, 1'(k < 4), 0),
                 $sformatf("seq_hold%0d", k));
        step(v(6'b100010, 0, 0, 0, 0, 3'b000, 1, 0), "seq_rst_mid_edit");
        step(v(6'b010000, 0, 0, 1, 0, 3'b000, 1, 0), "seq_tick_after_rst");

        // The 23:00:00 hour boundary: hours 23 + inc wraps to 0 in EDIT.
        step(v(6'b001000, 0, 0, 1, 1, 3'b100, 1, 0), "seq_edit2");
        step(v(6'b000001, 23, 0, 1, 1, 3'b100, 1, 0), "seq_h_dec");
        step(v(6'b000010, 0, 0, 1, 1, 3'b100, 1, 0), "seq_h_inc_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
